xor_cipher_key_loader: RTL and testbench

- Upstream configuration stage for dual_xor_stream_cipher (M-bit key chain).
- Collects the key as M/8 bytes from the host side.
- Serially shifts the key into the cipher via cfg_en/cfg_i, then shifts it a second time while checking the cipher's cfg_o readback.
- Reports pass/fail, so firmware knows the cipher holds the intended key before enabling tx_en/rx_en.

---
 rtl/xor_cipher_key_loader.sv | 161 ++++++++++++++++
 tb/tb_xor_cipher_key_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_cipher_key_loader.sv
// Key loader for the dual XOR stream cipher. It collects the key byte by byte, shifts it into
// the cipher's config chain, then shifts it a second time while checking the chain's readback.
module xor_cipher_key_loader #(
   parameter int M = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic       start,
   output logic       cfg_en,
   output logic       cfg_i,
   input  logic       cfg_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       fail,
   output logic [1:0] dbg_state_o
);

   localparam int BYTES = M / 8;
   localparam int CW    = $clog2(M) + 1;
   localparam int BW    = $clog2(BYTES + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [BW-1:0] BYTES_W  = BW'(BYTES);
   localparam logic [BW-1:0] BYTE_ONE = BW'(1);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_LOAD   = 2'd1,
      S_VERIFY = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   state_t          state_q;
   logic [BW-1:0]   count_q;
   logic [M-1:0]    key_q;
   logic [M-1:0]    rot_q;
   logic [CW-1:0]   cnt_q;
   logic            err_q;
   logic            cfg_en_q;
   logic            cfg_i_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic            fail_q;

   logic            count_full;
   logic            byte_accept;
   logic            cnt_last;
   logic            bit_err;
   logic            err_d;

   // Handshake: a byte transfers on a rising clk edge where byte_valid and byte_ready are both 1;
   // byte_ready depends only on registered state, never on byte_valid or start.
   always_comb begin
      count_full  = (count_q == BYTES_W);
      byte_ready  = (state_q == S_FILL) && !count_full;
      byte_accept = byte_ready && byte_valid;
      cnt_last    = (cnt_q == CNT_LAST);
      bit_err     = (cfg_o != cfg_i_q);
      err_d       = err_q | bit_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FILL;
         count_q  <= '0;
         key_q    <= '0;
         rot_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         cfg_en_q <= 1'b0;
         cfg_i_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_FILL: begin
               if (byte_accept) begin
                  for (int k = 0; k < BYTES; k++) begin
                     if (count_q == BW'(k)) begin
                        key_q[8*k +: 8] <= byte_in;
                     end
                  end
                  count_q <= count_q + BYTE_ONE;
               end
               // count is sampled before this edge's byte lands, so a start that arrives
               // together with the last byte is ignored.
               if (start && count_full) begin
                  state_q  <= S_LOAD;
                  cnt_q    <= '0;
                  err_q    <= 1'b0;
                  pass_q   <= 1'b0;
                  fail_q   <= 1'b0;
                  cfg_en_q <= 1'b1;
                  busy_q   <= 1'b1;
                  rot_q    <= key_q;
                  cfg_i_q  <= key_q[M-1];
               end
            end

            S_LOAD: begin
               // rot_q rotates left once per shift, so its bit M-2 is always the next key bit
               // MSB-first, wrapping naturally into the second pass.
               rot_q   <= {rot_q[M-2:0], rot_q[M-1]};
               cfg_i_q <= rot_q[M-2];
               if (cnt_last) begin
                  cnt_q   <= '0;
                  state_q <= S_VERIFY;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            S_VERIFY: begin
               rot_q   <= {rot_q[M-2:0], rot_q[M-1]};
               cfg_i_q <= rot_q[M-2];
               err_q   <= err_d;
               if (cnt_last) begin
                  cnt_q    <= '0;
                  state_q  <= S_REPORT;
                  cfg_en_q <= 1'b0;
                  cfg_i_q  <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  pass_q   <= ~err_d;
                  fail_q   <= err_d;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            S_REPORT: begin
               // The key stays in key_q, but a full new set of bytes is needed before the next start.
               count_q <= '0;
               state_q <= S_FILL;
            end

            default: begin
               state_q <= S_FILL;
            end
         endcase
      end
   end

   assign cfg_en      = cfg_en_q;
   assign cfg_i       = cfg_i_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_xor_cipher_key_loader.sv
// Bench for xor_cipher_key_loader: a model cipher chain of configurable length or stuck-at-0,
// table-driven load/verify runs, hand-written corner sequences and randomized keys.
module tb_xor_cipher_key_loader;

   localparam int M = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;
   logic       start;
   logic       cfg_en;
   logic       cfg_i;
   logic       cfg_o;
   logic       busy;
   logic       done;
   logic       pass;
   logic       fail;
   logic [1:0] dbg_state_o;

   int total = 0;
   int bad   = 0;

   logic [63:0] ch = '0;
   int          chain_len = 32;
   bit          stuck = 1'b0;

   typedef struct {
      logic [31:0] key;
      int          len;
      bit          stk;
      bit          exp_pass;
   } vec_t;

   vec_t tbl[7];

   xor_cipher_key_loader #(.M(M)) dut (
      .clk         (clk),
      .rst         (rst),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .start       (start),
      .cfg_en      (cfg_en),
      .cfg_i       (cfg_i),
      .cfg_o       (cfg_o),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .dbg_state_o (dbg_state_o)
   );

   always #5 clk = ~clk;

   // Model of the cipher config chain: shifts cfg_i in at the head when cfg_en is high.
   always @(posedge clk) begin
      if (cfg_en) ch <= {ch[62:0], cfg_i};
   end
   assign cfg_o = stuck ? 1'b0 : ch[chain_len-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Readback outcome from first principles: bit j of the serial stream is key MSB-first
   // repeated twice; the chain returns the bit sent len shifts earlier.
   function automatic bit model_pass(input logic [31:0] key, input int len, input bit stk);
      bit s[1:64];
      bit obs;
      for (int j = 1; j <= 2*M; j++) s[j] = key[M-1-((j-1)%M)];
      for (int j = M+1; j <= 2*M; j++) begin
         obs = stk ? 1'b0 : s[j-len];
         if (obs != s[j]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit with_start);
      repeat ($urandom_range(0, 2)) tick();
      byte_in    = b;
      byte_valid = 1'b1;
      start      = with_start;
      chk("byte_ready_fill", byte_ready, 1);
      tick();
      byte_valid = 1'b0;
      start      = 1'b0;
   endtask

   task automatic fill(input logic [31:0] key);
      for (int k = 0; k < M/8; k++) send_byte(key[8*k +: 8], 1'b0);
   endtask

   task automatic do_run(input string name, input logic [31:0] key, input bit exp_pass,
                         input bit noisy);
      int          en_n = 0;
      int          busy_n = 0;
      int          done_n = 0;
      int          done_at = 0;
      int          both = 0;
      int          ready_busy = 0;
      logic [63:0] stream = '0;
      logic [63:0] exp_stream;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, "_cleared_at_start"}, {pass, fail}, 2'b00);
      for (int j = 1; j <= 2*M + 2; j++) begin
         if (cfg_en) begin
            en_n++;
            stream = {stream[62:0], cfg_i};
         end
         if (busy) busy_n++;
         if (busy && byte_ready) ready_busy++;
         if (done) begin
            done_n++;
            done_at = j;
         end
         if (pass && fail) both++;
         if (noisy) begin
            start      = (j == 5 || j == 40);
            byte_valid = (j <= 2*M) ? 1'($urandom_range(0, 1)) : 1'b0;
            byte_in    = 8'($urandom);
         end
         tick();
      end
      start      = 1'b0;
      byte_valid = 1'b0;
      exp_stream = {key, key};
      chk({name, "_cfg_en_cycles"}, en_n, 2*M);
      chk({name, "_busy_cycles"}, busy_n, 2*M);
      chk({name, "_cfg_i_stream"}, stream, exp_stream);
      chk({name, "_done_count"}, done_n, 1);
      chk({name, "_done_cycle"}, done_at, 2*M + 1);
      chk({name, "_pass_fail_both"}, both, 0);
      chk({name, "_ready_while_busy"}, ready_busy, 0);
      chk({name, "_pass"}, pass, exp_pass);
      chk({name, "_fail"}, fail, !exp_pass);
      chk({name, "_ready_after"}, byte_ready, 1);
      if (chain_len == M && !stuck) chk({name, "_chain_holds_key"}, ch[31:0], key);
   endtask

   initial begin
      logic [31:0] rkey;
      bit          rexp;

      tbl[0] = '{32'h44332211, 31, 1'b0, 1'b0};
      tbl[1] = '{32'hFFFFFFFF, 32, 1'b1, 1'b0};
      tbl[2] = '{32'h44332211, 32, 1'b0, 1'b1};
      tbl[3] = '{32'hFFFFFFFF, 31, 1'b0, 1'b1};
      tbl[4] = '{32'hAAAAAAAA, 31, 1'b0, 1'b0};
      tbl[5] = '{32'hAAAAAAAA, 30, 1'b0, 1'b1};
      tbl[6] = '{32'h00000000, 32, 1'b1, 1'b1};

      rst        = 1'b1;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      start      = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_outputs", {byte_ready, cfg_en, cfg_i, busy, done, pass, fail}, 7'b1000000);
      chk("reset_state", dbg_state_o, 2'd0);

      fill(32'h44332211);
      do_run("fill_load", 32'h44332211, 1'b1, 1'b0);

      for (int i = 0; i < 7; i++) begin
         chain_len = tbl[i].len;
         stuck     = tbl[i].stk;
         fill(tbl[i].key);
         do_run($sformatf("tbl%0d", i), tbl[i].key, tbl[i].exp_pass, 1'b0);
      end
      chain_len = 32;
      stuck     = 1'b0;

      // Premature start, start together with the last byte, then an overflow byte.
      for (int k = 0; k < 3; k++) send_byte(8'(32'h5A3C0F96 >> (8*k)), 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("premature_busy", busy, 0);
      tick();
      chk("premature_busy_later", {busy, cfg_en}, 2'b00);
      chk("premature_result_kept", {pass, fail}, 2'b10);
      send_byte(8'h5A, 1'b1);
      chk("last_byte_start_ignored", busy, 0);
      chk("full_ready_low", byte_ready, 0);
      byte_in    = 8'h99;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
      chk("overflow_ready_low", byte_ready, 0);
      do_run("after_overflow", 32'h5A3C0F96, 1'b1, 1'b0);

      // Reset asserted during cycle 10 of LOAD.
      fill(32'h12345678);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      chk("mid_load_cfg_en_cycle10", {cfg_en, busy}, 2'b11);
      rst = 1'b1;
      tick();
      chk("mid_load_reset_outputs", {byte_ready, cfg_en, cfg_i, busy, done, pass, fail},
          7'b1000000);
      chk("mid_load_reset_state", dbg_state_o, 2'd0);
      rst = 1'b0;
      tick();
      chk("mid_load_stays_idle", {cfg_en, busy}, 2'b00);
      fill(32'h00FF5AA5);
      do_run("after_reset", 32'h00FF5AA5, 1'b1, 1'b0);

      // Start pulses and byte traffic while busy are all ignored.
      fill(32'h0F0F1234);
      do_run("busy_start", 32'h0F0F1234, 1'b1, 1'b1);

      for (int i = 0; i < 8; i++) begin
         rkey      = $urandom;
         chain_len = ($urandom_range(0, 3) == 0) ? 31 : 32;
         stuck     = ($urandom_range(0, 7) == 0);
         rexp      = model_pass(rkey, chain_len, stuck);
         fill(rkey);
         do_run($sformatf("rand%0d", i), rkey, rexp, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
